// File: rtl/nib2byte_pkg.sv
// Shared types and constants for the nibble-to-byte packer.
package nib2byte_pkg;

  localparam int unsigned NibW     = 4;
  localparam int unsigned ByteW    = 8;
  localparam int unsigned DefDepth = 4;

  typedef enum logic {
    StIdle,
    StHalf
  } pack_state_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/nib2byte_fifo.sv
// DEPTH x 8 circular-buffer FIFO. Pop is taken before push, so a full FIFO
// accepts a push in the same cycle it is popped.
module nib2byte_fifo
  import nib2byte_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ByteW-1:0] wdata,
  input  logic             pop,
  output logic [ByteW-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(DEPTH);

  logic [ByteW-1:0] mem_q [DEPTH];
  logic [ByteW-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             pop_en, push_en;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is reset too, so the head byte reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nib2byte.sv
// Packs nibble pairs into bytes, buffers them in a FIFO, flags dropped bytes.
// Define NIB2BYTE_STAT_EN to add the saturating drop_cnt output.
module nib2byte
  import nib2byte_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NibW-1:0]  din,
  input  logic             din_vld,
  input  logic             flush,
  output logic [ByteW-1:0] byte_out,
  output logic             byte_vld,
  input  logic             byte_rdy,
  output logic             ovf,
  input  logic             ovf_clr
`ifdef NIB2BYTE_STAT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  pack_state_e      state_q, state_d;
  logic [NibW-1:0]  hi_q, hi_d;
  logic             ovf_q, ovf_d;
  logic             byte_done;
  logic [ByteW-1:0] byte_data;
  logic             fifo_full, fifo_empty;
  logic             drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    if (flush) begin
      state_d = StIdle;
      hi_d    = '0;
    end else if (din_vld) begin
      unique case (state_q)
        StIdle: begin
          hi_d    = din;
          state_d = StHalf;
        end
        StHalf: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    byte_done = (state_q == StHalf) & din_vld & ~flush;
    byte_data = {hi_q, din};
  end

  // Full FIFO still takes the byte if the consumer pops the head this cycle.
  assign drop = byte_done & fifo_full & ~byte_rdy;

  nib2byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (byte_done),
    .wdata(byte_data),
    .pop  (byte_rdy),
    .rdata(byte_out),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign byte_vld = ~fifo_empty;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

`ifdef NIB2BYTE_STAT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] drop_base;

  // A clear and a drop together leave the count at one.
  always_comb begin
    drop_base  = ovf_clr ? 8'd0 : drop_cnt_q;
    drop_cnt_d = drop_base;
    if (drop && drop_base != 8'hff) drop_cnt_d = drop_base + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_nib2byte.sv
// Self-checking bench for nib2byte: vector table, directed corner cases and
// random traffic against a queue-based reference model.
module tb_nib2byte;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = '0;
  logic       din_vld = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] byte_out;
  logic       byte_vld;
  logic       byte_rdy = 1'b0;
  logic       ovf;
  logic       ovf_clr = 1'b0;
`ifdef NIB2BYTE_STAT_EN
  logic [7:0] drop_cnt;
`endif

  nib2byte #(
    .DEPTH(Depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .flush   (flush),
    .byte_out(byte_out),
    .byte_vld(byte_vld),
    .byte_rdy(byte_rdy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`ifdef NIB2BYTE_STAT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a byte queue, an optional held nibble, flag and count.
  logic [7:0] m_q[$];
  bit         m_held;
  logic [3:0] m_hi;
  bit         m_ovf;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_held = 0;
    m_hi   = '0;
    m_ovf  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [3:0] d, input bit v, input bit f, input bit r,
                            input bit c);
    bit dropped;
    dropped = 0;
    if (r && m_q.size() != 0) void'(m_q.pop_front());
    if (f) begin
      m_held = 0;
      m_hi   = '0;
    end else if (v) begin
      if (!m_held) begin
        m_hi   = d;
        m_held = 1;
      end else begin
        m_held = 0;
        if (m_q.size() < Depth) m_q.push_back({m_hi, d});
        else dropped = 1;
      end
    end
    if (c) begin
      m_ovf = 0;
      m_cnt = 0;
    end
    if (dropped) begin
      m_ovf = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_model();
    chk("byte_vld", 32'(byte_vld), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("byte_out", 32'(byte_out), 32'(m_q[0]));
    chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef NIB2BYTE_STAT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`endif
  endtask

  // One clock: drive, advance model, clock, compare just after the edge.
  task automatic step(input logic [3:0] d, input bit v, input bit f, input bit r,
                      input bit c);
    din = d; din_vld = v; flush = f; byte_rdy = r; ovf_clr = c;
    model_step(d, v, f, r, c);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(input bit r);
    step(4'h0, 0, 0, r, 0);
  endtask

  task automatic put_byte(input logic [7:0] b, input bit r);
    step(b[7:4], 1, 0, 0, 0);
    step(b[3:0], 1, 0, r, 0);
  endtask

  task automatic do_reset();
    din = '0; din_vld = 0; flush = 0; byte_rdy = 0; ovf_clr = 0;
    @(negedge clk);
    rst = 1;
    #2;
    model_reset();
    chk("rst_vld", 32'(byte_vld), 32'd0);
    chk("rst_out", 32'(byte_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
`ifdef NIB2BYTE_STAT_EN
    chk("rst_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic [3:0] d;
    bit         v;
    bit         f;
    bit         r;
    bit         c;
    bit         exp_vld;
    logic [7:0] exp_byte;
    bit         exp_ovf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    model_reset();

    // 0xA,0x5 -> 0xA5 one cycle later, valid for one cycle; then flush case.
    tbl.push_back('{4'hA, 1, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{4'h5, 1, 0, 1, 0, 1, 8'hA5, 0});
    tbl.push_back('{4'h0, 0, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{4'hC, 1, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{4'hE, 1, 1, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{4'h3, 1, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{4'h7, 1, 0, 1, 0, 1, 8'h37, 0});
    tbl.push_back('{4'h0, 0, 0, 1, 0, 0, 8'h00, 0});

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].v, tbl[i].f, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_vld", i), 32'(byte_vld), 32'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) chk($sformatf("tbl%0d_out", i), 32'(byte_out), 32'(tbl[i].exp_byte));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].exp_ovf));
    end

    // Overflow: five bytes into a four-deep FIFO, then drain in order.
    do_reset();
    for (int i = 1; i <= 5; i++) put_byte(8'(i * 'h11), 0);
    chk("ovf_set", 32'(ovf), 32'd1);
`ifdef NIB2BYTE_STAT_EN
    chk("ovf_cnt", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      chk("drain_vld", 32'(byte_vld), 32'd1);
      chk("drain_out", 32'(byte_out), 32'(i * 'h11));
      idle(1);
    end
    chk("drain_empty", 32'(byte_vld), 32'd0);

    // Full FIFO popped in the same cycle a byte completes.
    do_reset();
    for (int i = 1; i <= 4; i++) put_byte(8'(i * 'h11), 0);
    put_byte(8'h99, 1);
    chk("pp_ovf", 32'(ovf), 32'd0);
    begin
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'h22; exp_seq[1] = 8'h33; exp_seq[2] = 8'h44; exp_seq[3] = 8'h99;
      for (int i = 0; i < 4; i++) begin
        chk("pp_vld", 32'(byte_vld), 32'd1);
        chk("pp_out", 32'(byte_out), 32'(exp_seq[i]));
        idle(1);
      end
    end
    chk("pp_empty", 32'(byte_vld), 32'd0);

    // Reset with a nibble held and two bytes buffered.
    do_reset();
    put_byte(8'h5A, 0);
    put_byte(8'h6B, 0);
    step(4'h9, 1, 0, 0, 0);
    do_reset();
    put_byte(8'h12, 0);
    chk("post_rst_vld", 32'(byte_vld), 32'd1);
    chk("post_rst_out", 32'(byte_out), 32'h12);

    // ovf_clr coinciding with a drop keeps ovf set; clear alone then clears.
    do_reset();
    for (int i = 1; i <= 5; i++) put_byte(8'(i), 0);
    step(4'hF, 1, 0, 0, 0);
    step(4'hF, 1, 0, 0, 1);
    chk("clr_drop_ovf", 32'(ovf), 32'd1);
`ifdef NIB2BYTE_STAT_EN
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    step(4'h0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(ovf), 32'd0);
`ifdef NIB2BYTE_STAT_EN
    chk("clr_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) put_byte(8'hEE, 0);
    chk("sat_ovf", 32'(ovf), 32'd1);
`ifdef NIB2BYTE_STAT_EN
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nib2byte.md
# nib2byte

Downstream stage of the nibble serial link: consumes the 4-bit words and valid strobe produced by the serial-to-parallel receiver and packs consecutive nibble pairs into bytes. Completed bytes are buffered in a small FIFO and presented to the next consumer on a valid/ready handshake. A sticky overflow flag marks bytes dropped because the buffer was full.

## Interface
- DEPTH, 4, FIFO depth in bytes; power of two, 2..16
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  4  nibble from receiver (its dout)
- din_vld  input  1  nibble valid, one-cycle strobe per nibble (receiver dout_vld)
- flush  input  1  discard held partial nibble
- byte_out  output  8  FIFO head byte
- byte_vld  output  1  FIFO non-empty
- byte_rdy  input  1  consumer accepts head byte when byte_vld & byte_rdy
- ovf  output  1  sticky: a completed byte was dropped
- ovf_clr  input  1  clears ovf
- drop_cnt  output  8  dropped-byte count (only with NIB2BYTE_STAT_EN)

## Operation
- Packer states: IDLE (no nibble held) and HALF (high nibble held in hi_q).
- IDLE & din_vld: hi_q <= din, go HALF.
- HALF & din_vld: byte {hi_q, din} completes (first nibble = bits 7:4); go IDLE; push to FIFO.
- flush: forces IDLE, hi_q <= 0; a din_vld in the same cycle is ignored (flush wins).
- Push accepted when !full, or when full and a pop occurs the same cycle (pop-then-push).
- Push refused: byte discarded, ovf <= 1; packer still returns to IDLE.
- ovf_clr and a drop in the same cycle: ovf stays 1.
- Pop when byte_vld & byte_rdy; byte_rdy while empty has no effect.
- FIFO: circular buffer, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits; full = count==DEPTH, empty = count==0.
- byte_out stable while byte_vld & !byte_rdy.

## Timing
- Reset values: state IDLE, hi_q 0, pointers/count 0, byte_out 0, byte_vld 0, ovf 0, drop_cnt 0.
- Reset asserted mid-byte or with data buffered: all held data lost, outputs return to reset values immediately.
- Latency: second nibble sampled at edge N -> byte_vld=1 and byte_out valid in cycle after edge N (1 cycle) when FIFO was empty.
- byte_vld is a register-derived signal (count != 0), no combinational path from din/din_vld.
- byte_out driven from mem[rd_ptr]; no combinational path from byte_rdy to byte_out or byte_vld.
- Back-to-back din_vld every cycle supported: one byte per two cycles sustained.
- ovf sets the cycle after the refused push; clears the cycle after ovf_clr.

## Configuration
- NIB2BYTE_STAT_EN defined: drop_cnt port present; increments on every refused push, saturates at 255, cleared by ovf_clr (same priority as ovf: drop beats clear, counter then = previous+1 when a drop and clear coincide is not applied; it becomes 1).
- Undefined: drop_cnt port and counter absent; ovf behaviour unchanged.

## Structure
- Package nib2byte_pkg: default DEPTH, packer state enum (IDLE, HALF), nibble/byte width constants, ptr-width helper function.
- Sub-module nib2byte_fifo: parameterised DEPTH x 8 synchronous FIFO with push/pop/full/empty; packer and ovf/stat logic in top nib2byte.

## Test plan
- Nibbles 0xA then 0x5 on consecutive din_vld, byte_rdy=1 -> byte_out=0xA5, byte_vld high exactly one cycle, 1 cycle after second nibble.
- byte_rdy=0, push 5 bytes 0x11..0x55 with DEPTH=4 -> first 4 buffered, 0x55 dropped, ovf=1, drop_cnt=1; then byte_rdy=1 drains 0x11,0x22,0x33,0x44 in order.
- FIFO full, byte_rdy=1 same cycle a byte completes -> head popped, new byte accepted, ovf stays 0, count stays 4.
- Nibble 0xC, flush, then 0x3, 0x7 -> only byte 0x37 emitted; no 0xC3.
- Nibble 0x9 held plus 2 bytes buffered, rst pulsed -> byte_vld=0, byte_out=0, next pair 0x1,0x2 yields 0x12.
- ovf=1 with ovf_clr and a new drop in same cycle -> ovf remains 1; ovf_clr alone next cycle -> ovf=0, drop_cnt=0.
